// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, receiver FSM state encoding and
// a helper that gives the total frame length in bit periods.
package uart_pkg;

  localparam int unsigned UART_CHECK_NONE = 0;
  localparam int unsigned UART_CHECK_ODD  = 1;
  localparam int unsigned UART_CHECK_EVEN = 2;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } uart_rx_state_e;

  // Start bit + data bits + optional parity bit + stop bits.
  function automatic int unsigned uart_frame_len(input int unsigned dw,
                                                 input int unsigned check_on,
                                                 input int unsigned stop);
    return 1 + dw + ((check_on > 0) ? 1 : 0) + stop;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to 1 so an idle-high serial line does not look like a start bit.
// Ports:
//   i_clk   - sampling clock
//   i_rst_n - asynchronous active-low reset
//   i_d     - asynchronous input
//   o_q     - synchronised output (second flop)
module uart_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_d};
    end
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver clocked at the bit rate (one bit per i_clk cycle, no oversampling).
// Deframes start / data (LSB first) / optional parity / stop bits and presents one
// word per frame with a one-cycle valid pulse.
// Ports:
//   i_clk           - bit clock, rising edge
//   i_rst_n         - asynchronous active-low reset
//   i_uart_rx       - serial line, idles high
//   o_user_rx_data  - received word, held until the next frame completes
//   o_user_rx_valid - one-cycle pulse when data and error flags update
//   o_rx_check_err  - parity mismatch on the last frame
//   o_rx_stop_err   - a stop bit was sampled low on the last frame
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned P_SYSTEM_CLK      = 50_000_000,
  parameter int unsigned P_UART_BURD_RATE  = 9600,
  parameter int unsigned P_UART_DATA_WIDTH = 8,
  parameter int unsigned P_UART_CHECK_ON   = 1,
  parameter int unsigned P_UART_STOP_WIDTH = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_uart_rx,
  output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
  output logic                         o_user_rx_valid,
  output logic                         o_rx_check_err,
  output logic                         o_rx_stop_err
);

  localparam int unsigned LP_DW        = P_UART_DATA_WIDTH;
  localparam int unsigned LP_CW        = $clog2(LP_DW) + 1;
  localparam int unsigned LP_FRAME_LEN =
      uart_frame_len(LP_DW, P_UART_CHECK_ON, P_UART_STOP_WIDTH);

  // Rate parameters are informational only; frame length is kept for reference.
  logic w_unused_params;
  assign w_unused_params = (P_SYSTEM_CLK == 0) | (P_UART_BURD_RATE == 0) | (LP_FRAME_LEN == 0);

  logic w_rx_s;

  uart_sync2 u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_uart_rx),
    .o_q     (w_rx_s)
  );

  uart_rx_state_e   r_state,     w_state_d;
  logic [LP_CW-1:0] r_cnt,       w_cnt_d;
  logic [LP_DW-1:0] r_shift,     w_shift_d;
  logic             r_par,       w_par_d;
  logic             r_stop_acc,  w_stop_acc_d;
  logic [LP_DW-1:0] r_data,      w_data_d;
  logic             r_valid,     w_valid_d;
  logic             r_check_err, w_check_err_d;
  logic             r_stop_err,  w_stop_err_d;

  logic w_par_x;
  logic w_check_err;

  // XOR over data and received parity bit: 1 for odd total, 0 for even total.
  assign w_par_x = (^r_shift) ^ r_par;

  always_comb begin
    w_check_err = 1'b0;
    if (P_UART_CHECK_ON == UART_CHECK_ODD) begin
      w_check_err = ~w_par_x;
    end else if (P_UART_CHECK_ON == UART_CHECK_EVEN) begin
      w_check_err = w_par_x;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_shift_d     = r_shift;
    w_par_d       = r_par;
    w_stop_acc_d  = r_stop_acc;
    w_data_d      = r_data;
    w_valid_d     = 1'b0;
    w_check_err_d = r_check_err;
    w_stop_err_d  = r_stop_err;

    case (r_state)
      StIdle: begin
        if (!w_rx_s) begin
          w_state_d    = StData;
          w_cnt_d      = '0;
          w_stop_acc_d = 1'b0;
        end
      end
      StData: begin
        w_shift_d = {w_rx_s, r_shift[LP_DW-1:1]};
        w_cnt_d   = r_cnt + 1'b1;
        if (r_cnt == LP_CW'(LP_DW - 1)) begin
          w_cnt_d   = '0;
          w_state_d = (P_UART_CHECK_ON != UART_CHECK_NONE) ? StParity : StStop;
        end
      end
      StParity: begin
        w_par_d   = w_rx_s;
        w_state_d = StStop;
      end
      StStop: begin
        // A low stop sample is only an error, never a new start bit.
        w_stop_acc_d = r_stop_acc | ~w_rx_s;
        w_cnt_d      = r_cnt + 1'b1;
        if (r_cnt == LP_CW'(P_UART_STOP_WIDTH - 1)) begin
          w_state_d     = StIdle;
          w_valid_d     = 1'b1;
          w_data_d      = r_shift;
          w_check_err_d = w_check_err;
          w_stop_err_d  = r_stop_acc | ~w_rx_s;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_stop_acc  <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_check_err <= 1'b0;
      r_stop_err  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_shift     <= w_shift_d;
      r_par       <= w_par_d;
      r_stop_acc  <= w_stop_acc_d;
      r_data      <= w_data_d;
      r_valid     <= w_valid_d;
      r_check_err <= w_check_err_d;
      r_stop_err  <= w_stop_err_d;
    end
  end

  assign o_user_rx_data  = r_data;
  assign o_user_rx_valid = r_valid;
  assign o_rx_check_err  = r_check_err;
  assign o_rx_stop_err   = r_stop_err;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three receivers (odd parity / 1 stop, even parity / 1 stop,
// no parity / 2 stop) each fed by a bench-side serialiser; expected words, flags
// and delivery cycles come from a frame-level model and are checked at negedge.
module tb_uart_rx;
  import uart_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic       cerr;
    logic       serr;
    int         cyc;
  } exp_t;

  logic       clk;
  logic [2:0] rstn;
  logic       rx0, rx1, rx2;
  logic [7:0] odata [3];
  logic [2:0] ovalid, ocerr, oserr;

  int chk_cfg [3] = '{1, 2, 0};
  int stp_cfg [3] = '{1, 1, 2};

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t q0[$], q1[$], q2[$];
  logic [7:0] last [3] = '{8'h00, 8'h00, 8'h00};
  int   vlast [3] = '{0, 0, 0};
  int   vprev [3] = '{0, 0, 0};

  uart_rx #(.P_UART_DATA_WIDTH(8), .P_UART_CHECK_ON(1), .P_UART_STOP_WIDTH(1)) u_dut0 (
    .i_clk(clk), .i_rst_n(rstn[0]), .i_uart_rx(rx0), .o_user_rx_data(odata[0]),
    .o_user_rx_valid(ovalid[0]), .o_rx_check_err(ocerr[0]), .o_rx_stop_err(oserr[0])
  );
  uart_rx #(.P_UART_DATA_WIDTH(8), .P_UART_CHECK_ON(2), .P_UART_STOP_WIDTH(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rstn[1]), .i_uart_rx(rx1), .o_user_rx_data(odata[1]),
    .o_user_rx_valid(ovalid[1]), .o_rx_check_err(ocerr[1]), .o_rx_stop_err(oserr[1])
  );
  uart_rx #(.P_UART_DATA_WIDTH(8), .P_UART_CHECK_ON(0), .P_UART_STOP_WIDTH(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rstn[2]), .i_uart_rx(rx2), .o_user_rx_data(odata[2]),
    .o_user_rx_valid(ovalid[2]), .o_rx_check_err(ocerr[2]), .o_rx_stop_err(oserr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int d, output exp_t e, output bit ok);
    ok = 1'b0;
    case (d)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // The value set here is on the pin at the following rising edge.
  task automatic drive(input int d, input logic b);
    @(negedge clk);
    case (d)
      0: rx0 = b;
      1: rx1 = b;
      default: rx2 = b;
    endcase
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) drive(d, 1'b1);
  endtask

  // Parity bit that makes the frame correct under the given mode.
  function automatic logic good_par(input int chk, input logic [7:0] data);
    int ones;
    ones = $countones(data);
    return (chk == 1) ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1);
  endfunction

  // stop_mask bit i set drives stop bit i low.
  task automatic send_frame(input int d, input logic [7:0] data, input logic par,
                            input logic [1:0] stop_mask, input int gap);
    exp_t e;
    int   ones;
    e.data = data;
    e.cerr = 1'b0;
    e.serr = 1'b0;
    ones = $countones(data) + int'(par);
    if (chk_cfg[d] == 1) e.cerr = ((ones % 2) != 1);
    if (chk_cfg[d] == 2) e.cerr = ((ones % 2) != 0);
    drive(d, 1'b0);
    for (int i = 0; i < 8; i++) drive(d, data[i]);
    if (chk_cfg[d] != 0) drive(d, par);
    for (int i = 0; i < stp_cfg[d]; i++) begin
      drive(d, ~stop_mask[i]);
      if (stop_mask[i]) e.serr = 1'b1;
    end
    // Last stop bit on the pin at edge N -> valid seen after edge N+2.
    e.cyc = cyc + 3;
    push_exp(d, e);
    idle(d, gap);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rstn[d]) begin
        if (ovalid[d]) begin
          exp_t e;
          bit   ok;
          pop_exp(d, e, ok);
          if (!ok) begin
            check_eq($sformatf("d%0d_spurious_valid", d), 32'(ovalid[d]), 32'd0);
          end else begin
            check_eq($sformatf("d%0d_data", d), 32'(odata[d]), 32'(e.data));
            check_eq($sformatf("d%0d_check_err", d), 32'(ocerr[d]), 32'(e.cerr));
            check_eq($sformatf("d%0d_stop_err", d), 32'(oserr[d]), 32'(e.serr));
            check_eq($sformatf("d%0d_valid_cycle", d), 32'(cyc), 32'(e.cyc));
          end
          last[d]  = odata[d];
          vprev[d] = vlast[d];
          vlast[d] = cyc;
        end else begin
          check_eq($sformatf("d%0d_hold_data", d), 32'(odata[d]), 32'(last[d]));
        end
      end
    end
  end

  task automatic check_zero(input int d, input string tag);
    check_eq($sformatf("%s_d%0d_data", tag, d), 32'(odata[d]), 32'd0);
    check_eq($sformatf("%s_d%0d_valid", tag, d), 32'(ovalid[d]), 32'd0);
    check_eq($sformatf("%s_d%0d_cerr", tag, d), 32'(ocerr[d]), 32'd0);
    check_eq($sformatf("%s_d%0d_serr", tag, d), 32'(oserr[d]), 32'd0);
  endtask

  initial begin
    logic [7:0] w;
    logic [1:0] m;
    logic       p;
    int         d;

    rstn = 3'b000;
    rx0 = 1'b1;
    rx1 = 1'b1;
    rx2 = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_zero(i, "reset");
    rstn = 3'b111;
    idle(0, 5);

    // Odd parity 0xA5: correct parity, then parity bit forced to 0.
    send_frame(0, 8'hA5, 1'b1, 2'b00, 4);
    send_frame(0, 8'hA5, 1'b0, 2'b00, 4);
    // Even parity 0xA5 with a low stop bit.
    send_frame(1, 8'hA5, 1'b0, 2'b01, 4);
    // Back-to-back frames with no idle gap.
    send_frame(0, 8'h3C, good_par(1, 8'h3C), 2'b00, 0);
    send_frame(0, 8'hC3, good_par(1, 8'hC3), 2'b00, 6);
    check_eq("b2b_spacing", 32'(vlast[0] - vprev[0]), 32'(uart_frame_len(8, 1, 1)));

    // No parity, two stop bits; then reset in the middle of a frame.
    send_frame(2, 8'h00, 1'b0, 2'b00, 3);
    send_frame(2, 8'hFF, 1'b0, 2'b10, 3);
    w = 8'h5A;
    drive(2, 1'b0);
    for (int i = 0; i < 5; i++) drive(2, w[i]);
    #2 rstn[2] = 1'b0;
    @(negedge clk);
    rx2 = 1'b1;
    repeat (2) @(negedge clk);
    check_zero(2, "midframe_reset");
    last[2] = 8'h00;
    rstn[2] = 1'b1;
    idle(2, 20);
    send_frame(2, 8'h5A, 1'b0, 2'b00, 4);

    // Long idle, then random clean traffic with small random gaps.
    idle(0, 100);
    for (int i = 0; i < 256; i++) begin
      w = 8'($urandom);
      send_frame(0, w, good_par(1, w), 2'b00, $urandom_range(0, 2));
    end
    idle(0, 4);

    // Random traffic with occasional parity and stop errors.
    for (int i = 0; i < 64; i++) begin
      d = 1 + $urandom_range(0, 1);
      w = 8'($urandom);
      p = good_par(chk_cfg[d], w) ^ ($urandom_range(0, 3) == 0);
      m = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send_frame(d, w, p, m, $urandom_range(0, 2));
      idle(d, 1);
    end

    idle(0, 10);
    check_eq("q0_drained", 32'(q0.size()), 32'd0);
    check_eq("q1_drained", 32'(q1.size()), 32'd0);
    check_eq("q2_drained", 32'(q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL timeout: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
